// File: rtl/pr_release_packer_pkg.sv
// rtl/pr_release_packer_pkg.sv - shared rename types for the PR release packer
package pr_release_packer_pkg;

  localparam int PR_W  = 6;
  localparam int LANES = 4;

  typedef logic [PR_W-1:0] pr_t;
  typedef logic [2:0]      lane_cnt_t;

endpackage

// File: rtl/pr_lane_compactor.sv
// rtl/pr_lane_compactor.sv - packs sparse valid retire lanes into contiguous low lanes
module pr_lane_compactor
  import pr_release_packer_pkg::*;
(
  input  logic [LANES-1:0] i_valid,
  input  pr_t  [LANES-1:0] i_pr,
  output pr_t  [LANES-1:0] o_pr,
  output lane_cnt_t        o_count
);

  // Running count doubles as the write slot, so lane order is preserved.
  always_comb begin
    o_pr    = '0;
    o_count = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i_valid[i]) begin
        o_pr[o_count[1:0]] = i_pr[i];
        o_count            = o_count + 3'd1;
      end
    end
  end

endmodule

// File: rtl/pr_release_packer.sv
// rtl/pr_release_packer.sv - compacts retiring PRs into a circular queue and drains them to the free list
module pr_release_packer
  import pr_release_packer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               cmt_valid,
  input  logic [5:0]               cmt_pr0,
  input  logic [5:0]               cmt_pr1,
  input  logic [5:0]               cmt_pr2,
  input  logic [5:0]               cmt_pr3,
  output logic                     cmt_ready,
  input  logic                     stall,
  input  logic                     list_empty,
  output logic [5:0]               free_pr_num_in0,
  output logic [5:0]               free_pr_num_in1,
  output logic [5:0]               free_pr_num_in2,
  output logic [5:0]               free_pr_num_in3,
  output logic [2:0]               free_pr_num,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pr_t              r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  pr_t [LANES-1:0]  w_cmt_pr;
  pr_t [LANES-1:0]  w_packed;
  pr_t [LANES-1:0]  w_drain;
  lane_cnt_t        w_push_n;
  lane_cnt_t        w_pop_n;
  logic             w_push;
  logic             w_drain_en;

  assign w_cmt_pr = {cmt_pr3, cmt_pr2, cmt_pr1, cmt_pr0};

  pr_lane_compactor u_compactor (
    .i_valid (cmt_valid),
    .i_pr    (w_cmt_pr),
    .o_pr    (w_packed),
    .o_count (w_push_n)
  );

  // Leaving room for a full retire keeps push slots disjoint from drain slots.
  assign cmt_ready  = (r_count <= CNT_W'(DEPTH - LANES));
  assign w_push     = cmt_ready && (cmt_valid != '0);
  assign w_drain_en = !stall && !list_empty;

  always_comb begin
    w_pop_n = '0;
    if (w_drain_en) begin
      w_pop_n = (r_count >= CNT_W'(LANES)) ? lane_cnt_t'(LANES) : lane_cnt_t'(r_count);
    end
    for (int k = 0; k < LANES; k++) begin
      w_drain[k] = (lane_cnt_t'(k) < w_pop_n) ? r_mem[r_head + PTR_W'(k)] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int j = 0; j < LANES; j++) begin
        if (lane_cnt_t'(j) < w_push_n) begin
          r_mem[r_tail + PTR_W'(j)] <= w_packed[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(w_push_n);
      end
      r_head  <= r_head + PTR_W'(w_pop_n);
      r_count <= r_count + (w_push ? CNT_W'(w_push_n) : CNT_W'(0)) - CNT_W'(w_pop_n);
      if ((cmt_valid != '0) && !cmt_ready) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign free_pr_num     = w_pop_n;
  assign free_pr_num_in0 = w_drain[0];
  assign free_pr_num_in1 = w_drain[1];
  assign free_pr_num_in2 = w_drain[2];
  assign free_pr_num_in3 = w_drain[3];
  assign occupancy       = r_count;
  assign overflow_err    = r_ovf;

endmodule
